// File: rtl/msrv32_pkg.sv
// Shared msrv32 definitions: PC source encodings and the PC sequencer state type.
package msrv32_pkg;

  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_EPC  = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP = 2'b10;
  localparam logic [1:0] PC_SRC_NEXT = 2'b11;

  typedef enum logic [1:0] {
    BOOT_WAIT,
    RUN,
    HOLD
  } pc_state_t;

endpackage

// File: rtl/msrv32_pc_target_mux.sv
// Redirect target selection and IALIGN misalignment check for the PC sequencer.
module msrv32_pc_target_mux
  import msrv32_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IALIGN = 32
) (
  input  logic [1:0]      pc_src_in,
  input  logic [XLEN-1:0] boot_address_in,
  input  logic [XLEN-1:0] epc_in,
  input  logic [XLEN-1:0] trap_address_in,
  input  logic [XLEN-2:0] iaddr_in,
  input  logic            branch_taken_in,
  output logic [XLEN-1:0] target_out,
  output logic            redirect_out,
  output logic            misaligned_out
);

  localparam bit WORD_ALIGNED = (IALIGN == 32);

  logic w_redirect_raw;

  always_comb begin
    target_out = {iaddr_in, 1'b0};
    unique case (pc_src_in)
      PC_SRC_BOOT: target_out = boot_address_in;
      PC_SRC_EPC:  target_out = epc_in;
      PC_SRC_TRAP: target_out = trap_address_in;
      PC_SRC_NEXT: target_out = {iaddr_in, 1'b0};
      default:     target_out = {iaddr_in, 1'b0};
    endcase
  end

  assign w_redirect_raw = (pc_src_in != PC_SRC_NEXT) || branch_taken_in;

  // A misaligned branch target is dropped here; the trap unit redirects next cycle.
  assign misaligned_out = branch_taken_in && (pc_src_in == PC_SRC_NEXT) &&
                          target_out[1] && WORD_ALIGNED;
  assign redirect_out   = w_redirect_raw && !misaligned_out;

endmodule

// File: rtl/msrv32_pc_seq.sv
// Program counter / fetch-address sequencer with boot delay and stall-safe redirect capture.
module msrv32_pc_seq
  import msrv32_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] BOOT_ADDRESS = '0,
  parameter int unsigned     IALIGN       = 32,
  parameter int unsigned     BOOT_DELAY   = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [1:0]      pc_src_in,
  input  logic [XLEN-1:0] epc_in,
  input  logic [XLEN-1:0] trap_address_in,
  input  logic [XLEN-2:0] iaddr_in,
  input  logic            branch_taken_in,
  input  logic            ahb_ready_in,
  output logic [XLEN-1:0] i_addr_out,
  output logic            i_req_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_inc_out,
  output logic            redirect_pending_out,
  output logic            misaligned_instr_logic_out
);

  localparam int unsigned     CW       = (BOOT_DELAY > 0) ? $clog2(BOOT_DELAY + 1) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'((BOOT_DELAY > 0) ? BOOT_DELAY - 1 : 0);
  localparam logic [XLEN-1:0] INC      = XLEN'(IALIGN / 8);

  pc_state_t       r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [XLEN-1:0] r_i_addr, w_i_addr_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_pend_addr, w_pend_addr_nxt;
  logic            r_i_req, w_i_req_nxt;
  logic            r_pending, w_pending_nxt;
  logic [XLEN-1:0] w_target;
  logic            w_redirect;
  logic            w_accept;

  msrv32_pc_target_mux #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_target_mux (
    .pc_src_in       (pc_src_in),
    .boot_address_in (BOOT_ADDRESS),
    .epc_in          (epc_in),
    .trap_address_in (trap_address_in),
    .iaddr_in        (iaddr_in),
    .branch_taken_in (branch_taken_in),
    .target_out      (w_target),
    .redirect_out    (w_redirect),
    .misaligned_out  (misaligned_instr_logic_out)
  );

  assign w_accept = r_i_req && ahb_ready_in;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_i_addr_nxt    = r_i_addr;
    w_pc_nxt        = r_pc;
    w_pend_addr_nxt = r_pend_addr;
    w_i_req_nxt     = r_i_req;
    w_pending_nxt   = r_pending;
    unique case (r_state)
      BOOT_WAIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (BOOT_DELAY == 0 || r_cnt == CNT_LAST) begin
          w_state_nxt  = RUN;
          w_i_req_nxt  = 1'b1;
          w_i_addr_nxt = BOOT_ADDRESS;
        end
      end
      RUN: begin
        if (w_accept) begin
          w_pc_nxt     = r_i_addr;
          w_i_addr_nxt = w_redirect ? w_target : r_i_addr + INC;
        end else if (w_redirect) begin
          w_pend_addr_nxt = w_target;
          w_pending_nxt   = 1'b1;
          w_state_nxt     = HOLD;
        end
      end
      HOLD: begin
        // Newest redirect wins, including one arriving in the accept cycle.
        if (w_redirect) w_pend_addr_nxt = w_target;
        if (w_accept) begin
          w_pc_nxt      = r_i_addr;
          w_i_addr_nxt  = w_redirect ? w_target : r_pend_addr;
          w_pending_nxt = 1'b0;
          w_state_nxt   = RUN;
        end
      end
      default: w_state_nxt = BOOT_WAIT;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= BOOT_WAIT;
      r_cnt       <= '0;
      r_i_addr    <= BOOT_ADDRESS;
      r_pc        <= BOOT_ADDRESS;
      r_pend_addr <= '0;
      r_i_req     <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_i_addr    <= w_i_addr_nxt;
      r_pc        <= w_pc_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_i_req     <= w_i_req_nxt;
      r_pending   <= w_pending_nxt;
    end
  end

  assign i_addr_out           = r_i_addr;
  assign i_req_out            = r_i_req;
  assign pc_out               = r_pc;
  assign pc_plus_inc_out      = r_pc + INC;
  assign redirect_pending_out = r_pending;

endmodule
